// File: rtl/perm_pkg.sv
// Shared constants and types for the Keccak-f[1600] permutation datapath.
package perm_pkg;

  localparam int unsigned X_AXIS  = 5;
  localparam int unsigned Y_AXIS  = 5;
  localparam int unsigned Z_AXIS  = 64;
  localparam int unsigned BEAT_W  = 200;
  localparam int unsigned NBEATS  = 8;
  localparam int unsigned STATE_W = NBEATS * BEAT_W;

  typedef logic [2:0] ix_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } unload_st_e;

  // Bit offset of lane(x,y) inside the flat state vector.
  function automatic int unsigned lane_lsb(input int unsigned x, input int unsigned y);
    return Z_AXIS * (x + X_AXIS * y);
  endfunction

endpackage

// File: rtl/perm_unloader.sv
// Serialises one captured 1600-bit permuted state into 200-bit indexed beats.
// Build option PERM_UNLOAD_DIGEST_EN: emit only beats 0..1 (SHA3-256 digest).
module perm_unloader
  import perm_pkg::*;
#(
  parameter int unsigned NBEATS = 8,
  parameter int unsigned BEAT_W = 200
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  input  logic [NBEATS*BEAT_W-1:0]   st_data,
  output logic                       st_ready,
  input  logic                       stopin,
  output logic                       pushout,
  output logic [2:0]                 doutix,
  output logic [BEAT_W-1:0]          dout,
  output logic                       busy
);

`ifdef PERM_UNLOAD_DIGEST_EN
  localparam ix_t LAST_IX = 3'd1;
`else
  localparam ix_t LAST_IX = ix_t'(NBEATS - 1);
`endif

  unload_st_e                state_q, state_d;
  ix_t                       ix_q, ix_d;
  logic [BEAT_W-1:0]         dout_q, dout_d;
  logic [NBEATS*BEAT_W-1:0]  shadow_q;

  logic take;
  logic last;
  logic ready;
  logic capture;
  ix_t  nxt_ix;

  assign take    = (state_q == SEND) && !stopin;
  assign last    = (ix_q == LAST_IX);
  assign ready   = (state_q == IDLE) || (take && last);
  assign capture = st_valid && ready;
  assign nxt_ix  = ix_q + 3'd1;

  always_comb begin
    state_d = state_q;
    ix_d    = ix_q;
    dout_d  = dout_q;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = SEND;
          ix_d    = '0;
          dout_d  = st_data[BEAT_W-1:0];
        end
      end
      SEND: begin
        if (take) begin
          if (last) begin
            // Beat 0 of a newly captured state comes straight from st_data,
            // since the shadow register only updates at this same edge.
            if (st_valid) begin
              ix_d   = '0;
              dout_d = st_data[BEAT_W-1:0];
            end else begin
              state_d = IDLE;
            end
          end else begin
            ix_d   = nxt_ix;
            dout_d = shadow_q[BEAT_W*nxt_ix +: BEAT_W];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ix_q     <= '0;
      dout_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q <= state_d;
      ix_q    <= ix_d;
      dout_q  <= dout_d;
      if (capture) begin
        shadow_q <= st_data;
      end
    end
  end

  assign st_ready = ready && !reset;
  assign pushout  = (state_q == SEND);
  assign busy     = (state_q == SEND);
  assign doutix   = ix_q;
  assign dout     = dout_q;

endmodule
